// File: rtl/AMITypes.sv
// AMI request/response beat types shared by the DNN2AMI initiator and memory-side targets.
package AMITypes;
    localparam int AMI_ADDR_WIDTH = 64;
    localparam int AMI_DATA_WIDTH = 512;
    localparam int AMI_SIZE_WIDTH = 64;

    typedef struct packed {
        logic                      valid;
        logic                      isWrite;
        logic [AMI_ADDR_WIDTH-1:0] addr;
        logic [AMI_DATA_WIDTH-1:0] data;
        logic [AMI_SIZE_WIDTH-1:0] size;
    } AMIRequest;

    typedef struct packed {
        logic                      valid;
        logic [AMI_DATA_WIDTH-1:0] data;
        logic [AMI_SIZE_WIDTH-1:0] size;
    } AMIResponse;
endpackage

// File: rtl/ami_mem_responder_pkg.sv
// Shared sizing constants and the response FIFO entry layout for the AMI memory responder.
package ami_mem_responder_pkg;
    import AMITypes::*;

    localparam int MEM_DEPTH_DFLT       = 1024;
    localparam int RESP_FIFO_DEPTH_DFLT = 8;
    localparam int IDX_W                = $clog2(MEM_DEPTH_DFLT);
    localparam int CNT_W                = $clog2(RESP_FIFO_DEPTH_DFLT) + 1;

    typedef struct packed {
        logic [AMI_DATA_WIDTH-1:0] data;
        logic [AMI_SIZE_WIDTH-1:0] size;
    } resp_entry_t;

    localparam int RESP_ENTRY_W = $bits(resp_entry_t);
endpackage

// File: rtl/ami_resp_fifo.sv
// Synchronous response FIFO with occupancy count; head reads as zero while empty.
module ami_resp_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (PW+1)'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    // A pop frees the head slot at the same edge, so a full FIFO may still accept.
    assign w_push  = i_push & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/ami_mem_responder.sv
// AMI memory-side target: word-array backing store, fixed-latency read pipeline and
// a credit-limited in-order response FIFO.
module ami_mem_responder
    import AMITypes::*;
    import ami_mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH       = MEM_DEPTH_DFLT,
    parameter int READ_LATENCY    = 2,
    parameter int RESP_FIFO_DEPTH = RESP_FIFO_DEPTH_DFLT,
    parameter int ADDR_LSB        = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  AMIRequest   mem_req,
    output logic        mem_req_grant,
    output AMIResponse  mem_resp,
    input  logic        mem_resp_grant,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);
    localparam int MEM_IDX_W = $clog2(MEM_DEPTH);
    localparam int OUT_W     = $clog2(RESP_FIFO_DEPTH) + 1;

    logic [AMI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [MEM_IDX_W-1:0]      w_idx;
    logic                      w_acc;
    logic                      w_rd_acc;
    logic                      w_wr_acc;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_unused_addr;

    logic                      r_grant;
    logic [OUT_W-1:0]          r_outstanding;
    logic [OUT_W-1:0]          w_out_nxt;
    logic [31:0]               r_rd_count;
    logic [31:0]               r_wr_count;

    logic [READ_LATENCY:0]     r_vld_p;
    resp_entry_t               r_ent_p [READ_LATENCY+1];
    resp_entry_t               w_head;
    logic [OUT_W-1:0]          w_fifo_count;

    assign w_idx         = mem_req.addr[ADDR_LSB +: MEM_IDX_W];
    assign w_unused_addr = ^{mem_req.addr[AMI_ADDR_WIDTH-1:ADDR_LSB+MEM_IDX_W],
                             mem_req.addr[ADDR_LSB-1:0]};

    assign w_acc     = mem_req.valid & r_grant;
    assign w_wr_acc  = w_acc & mem_req.isWrite;
    assign w_rd_acc  = w_acc & ~mem_req.isWrite;
    assign w_push    = r_vld_p[READ_LATENCY];
    assign w_pop     = mem_resp.valid & mem_resp_grant;
    assign w_out_nxt = r_outstanding + OUT_W'(w_rd_acc) - OUT_W'(w_pop);

    // Credit and counter state; grant is a register so it never depends on this cycle's inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant       <= 1'b0;
            r_outstanding <= '0;
            r_rd_count    <= '0;
            r_wr_count    <= '0;
        end else begin
            r_grant       <= (w_out_nxt < OUT_W'(RESP_FIFO_DEPTH));
            r_outstanding <= w_out_nxt;
            if (w_rd_acc) r_rd_count <= r_rd_count + 32'd1;
            if (w_wr_acc) r_wr_count <= r_wr_count + 32'd1;
        end
    end

    // Stage p0: synchronous array read; a write one cycle earlier is already visible.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[w_idx] <= mem_req.data;
        r_ent_p[0].data <= r_mem[w_idx];
        r_ent_p[0].size <= mem_req.size;
    end

    // Stages p1..pN: latency delay line, valid tag reset, payload free-running.
    always_ff @(posedge clk) begin
        for (int i = 1; i <= READ_LATENCY; i++) begin
            r_ent_p[i] <= r_ent_p[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_vld_p <= '0;
        else        r_vld_p <= {r_vld_p[READ_LATENCY-1:0], w_rd_acc};
    end

    ami_resp_fifo #(
        .DEPTH (RESP_FIFO_DEPTH),
        .W     (RESP_ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (r_ent_p[READ_LATENCY]),
        .i_pop       (mem_resp_grant),
        .o_head      (w_head),
        .o_count     (w_fifo_count)
    );

    assign mem_resp.valid = (w_fifo_count != '0);
    assign mem_resp.data  = w_head.data;
    assign mem_resp.size  = w_head.size;
    assign mem_req_grant  = r_grant;
    assign rd_count       = r_rd_count;
    assign wr_count       = r_wr_count;
endmodule

// File: tb/tb_ami_mem_responder.sv
// Directed + randomized bench for ami_mem_responder against a transaction-level model
// (word array, expected-response queue with ready times, credit count).
module tb_ami_mem_responder;
    import AMITypes::*;

    localparam int MEM_DEPTH       = 1024;
    localparam int READ_LATENCY    = 2;
    localparam int RESP_FIFO_DEPTH = 8;
    localparam int ADDR_LSB        = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    AMIRequest   mem_req;
    logic        mem_req_grant;
    AMIResponse  mem_resp;
    logic        mem_resp_grant;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    always #5 clk = ~clk;

    ami_mem_responder #(
        .MEM_DEPTH       (MEM_DEPTH),
        .READ_LATENCY    (READ_LATENCY),
        .RESP_FIFO_DEPTH (RESP_FIFO_DEPTH),
        .ADDR_LSB        (ADDR_LSB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_req_grant  (mem_req_grant),
        .mem_resp       (mem_resp),
        .mem_resp_grant (mem_resp_grant),
        .rd_count       (rd_count),
        .wr_count       (wr_count)
    );

    typedef struct {
        logic [511:0] data;
        logic [63:0]  size;
        int unsigned  ready;
    } exp_t;

    exp_t         m_q[$];
    logic [511:0] m_mem [MEM_DEPTH];
    int unsigned  m_out = 0;
    int unsigned  m_rd = 0;
    int unsigned  m_wr = 0;
    int unsigned  n_resp = 0;
    int unsigned  cyc = 0;
    int           checks = 0;
    int           errors = 0;

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock cycle: drive, check against model, advance model, step past the edge.
    task automatic step(input bit v, input bit w, input logic [63:0] a, input logic [511:0] d,
                        input logic [63:0] sz, input bit rg, output bit acc);
        bit          gexp;
        bit          vexp;
        bit          pop;
        int unsigned idx;
        mem_req.valid   = v;
        mem_req.isWrite = w;
        mem_req.addr    = a;
        mem_req.data    = d;
        mem_req.size    = sz;
        mem_resp_grant  = rg;
        #1;
        gexp = (m_out < RESP_FIFO_DEPTH);
        vexp = (m_q.size() != 0) && (m_q[0].ready <= cyc);
        chk_i("req_grant", int'(mem_req_grant), int'(gexp));
        chk_i("resp_valid", int'(mem_resp.valid), int'(vexp));
        chk_w("rd_count", 512'(rd_count), 512'(m_rd));
        chk_w("wr_count", 512'(wr_count), 512'(m_wr));
        chk_i("fifo_bound", (int'(dut.u_fifo.o_count) <= RESP_FIFO_DEPTH) ? 1 : 0, 1);
        if (vexp) begin
            chk_w("resp_data", mem_resp.data, m_q[0].data);
            chk_w("resp_size", 512'(mem_resp.size), 512'(m_q[0].size));
        end
        acc = v && gexp;
        pop = vexp && rg;
        if (pop) begin
            m_q.delete(0);
            m_out--;
            n_resp++;
        end
        idx = int'((a >> ADDR_LSB) % 64'(MEM_DEPTH));
        if (acc && w) begin
            m_mem[idx] = d;
            m_wr++;
        end else if (acc) begin
            m_q.push_back(exp_t'{m_mem[idx], sz, cyc + READ_LATENCY + 2});
            m_rd++;
            m_out++;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input bit rg);
        bit acc;
        step(1'b0, 1'b0, 64'h0, 512'h0, 64'h0, rg, acc);
    endtask

    task automatic drain();
        int n = 0;
        while (m_q.size() != 0 && n < 60) begin
            idle(1'b1);
            n++;
        end
        chk_i("drain", int'(m_q.size()), 0);
    endtask

    task automatic do_reset(input int hold);
        rst_n          = 1'b0;
        mem_req        = '0;
        mem_resp_grant = 1'b0;
        #1;
        m_q.delete();
        m_out = 0;
        m_rd  = 0;
        m_wr  = 0;
        chk_i("rst_grant", int'(mem_req_grant), 0);
        chk_i("rst_valid", int'(mem_resp.valid), 0);
        chk_w("rst_data", mem_resp.data, 512'h0);
        chk_w("rst_size", 512'(mem_resp.size), 512'h0);
        chk_w("rst_rd_count", 512'(rd_count), 512'h0);
        chk_w("rst_wr_count", 512'(wr_count), 512'h0);
        repeat (hold) begin
            @(posedge clk);
            cyc++;
        end
        #1 rst_n = 1'b1;
        #1;
        chk_i("release_grant", int'(mem_req_grant), 0);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        logic [511:0] pat;
        logic [511:0] wd;
        bit           acc;
        int           n;
        int           issued;
        int unsigned  base;
        int unsigned  wr_before;

        mem_req        = '0;
        mem_resp_grant = 1'b0;
        #2;
        do_reset(2);

        // Write then immediate read of the same word; response 3 cycles after accept.
        pat = {64{8'hA5}};
        step(1'b1, 1'b1, 64'h40, pat, 64'd64, 1'b0, acc);
        step(1'b1, 1'b0, 64'h40, 512'h0, 64'd64, 1'b0, acc);
        n = 0;
        while (!mem_resp.valid && n < 10) begin
            idle(1'b0);
            n++;
        end
        chk_i("t1_latency", n, 3);
        chk_w("t1_data", mem_resp.data, pat);
        chk_w("t1_size", 512'(mem_resp.size), 512'd64);
        chk_w("t1_rd_count", 512'(rd_count), 512'd1);
        chk_w("t1_wr_count", 512'(wr_count), 512'd1);
        drain();

        // Address wrap modulo MEM_DEPTH words.
        step(1'b1, 1'b1, 64'h0, 512'h1, 64'd64, 1'b0, acc);
        step(1'b1, 1'b0, 64'h10000, 512'h0, 64'd64, 1'b0, acc);
        n = 0;
        while (!mem_resp.valid && n < 10) begin
            idle(1'b0);
            n++;
        end
        chk_w("t2_wrap_data", mem_resp.data, 512'h1);
        drain();

        for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 64'(i * 64), rand512(), 64'd64, 1'b1, acc);

        // Credit exhaustion with the consumer stalled, then release.
        base   = n_resp;
        issued = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 64'((issued % 32) * 64), 512'h0, 64'(issued + 1), 1'b0, acc);
            if (acc) issued++;
        end
        chk_i("t3_credit_stop", issued, RESP_FIFO_DEPTH);
        n = 0;
        while (issued < 12 && n < 100) begin
            step(1'b1, 1'b0, 64'((issued % 32) * 64), 512'h0, 64'(issued + 1), 1'b1, acc);
            if (acc) issued++;
            n++;
        end
        chk_i("t3_all_issued", issued, 12);
        drain();
        chk_i("t3_resp_total", int'(n_resp - base), 12);

        // Write blocked while credits are exhausted, accepted once a pop frees one.
        for (int i = 0; i < RESP_FIFO_DEPTH; i++) step(1'b1, 1'b0, 64'(i * 64), 512'h0, 64'd64, 1'b0, acc);
        wr_before = m_wr;
        wd = rand512();
        n  = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 64'h0, wd, 64'd64, 1'b0, acc);
            if (acc) n++;
        end
        chk_i("t6_wr_blocked", n, 0);
        chk_w("t6_wr_count_held", 512'(wr_count), 512'(wr_before));
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 10) begin
            step(1'b1, 1'b1, 64'h0, wd, 64'd64, 1'b1, acc);
            n++;
        end
        chk_i("t6_wr_after_pop", n, 2);
        drain();

        // Random mixed traffic with a random consumer; high address bits are noise.
        for (int i = 0; i < 300; i++) begin
            step(($urandom % 4) != 0, ($urandom % 5) == 0,
                 (64'($urandom) << 16) | 64'(($urandom % 32) * 64),
                 rand512(), 64'($urandom), 1'($urandom % 2), acc);
        end
        drain();

        // Reset with reads in flight: nothing stale afterwards, memory retained.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'(i * 64), 512'h0, 64'd64, 1'b0, acc);
        do_reset(2);
        for (int i = 0; i < 10; i++) idle(1'b1);
        step(1'b1, 1'b0, 64'h40, 512'h0, 64'd64, 1'b1, acc);
        chk_i("t5_read_accepted", int'(acc), 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
